// File: rtl/ex_stage_pkg.sv
// Shared widths, opcode constants and multiplier state encoding for the EX stage.
package ex_stage_pkg;

    localparam int RegBus    = 64;
    localparam int OpCodeBus = 11;
    localparam int ShamtBus  = 6;
    localparam int AluOpBus  = 2;
    localparam int MulCntW   = 7;

    localparam logic [AluOpBus-1:0] AluOpAdd    = 2'b00;
    localparam logic [AluOpBus-1:0] AluOpPass   = 2'b01;
    localparam logic [AluOpBus-1:0] AluOpDecode = 2'b10;

    localparam logic [OpCodeBus-1:0] OpAdd   = 11'b10001011000;
    localparam logic [OpCodeBus-1:0] OpSub   = 11'b11001011000;
    localparam logic [OpCodeBus-1:0] OpAnd   = 11'b10001010000;
    localparam logic [OpCodeBus-1:0] OpOrr   = 11'b10101010000;
    localparam logic [OpCodeBus-1:0] OpLsl   = 11'b11010011011;
    localparam logic [OpCodeBus-1:0] OpLsr   = 11'b11010011010;
    localparam logic [OpCodeBus-1:0] OpMul   = 11'b10011011000;
    localparam logic [OpCodeBus-1:0] OpUmulh = 11'b10011011110;

    // Immediate forms carry an extra immediate bit in opcode[0], so only [10:1] is compared.
    localparam logic [OpCodeBus-2:0] OpAddi = 10'b1001000100;
    localparam logic [OpCodeBus-2:0] OpSubi = 10'b1101000100;
    localparam logic [OpCodeBus-2:0] OpAndi = 10'b1001001000;
    localparam logic [OpCodeBus-2:0] OpOrri = 10'b1011001000;

    typedef enum logic [1:0] {
        MulIdle = 2'd0,
        MulBusy = 2'd1,
        MulDone = 2'd2
    } mul_state_e;

    function automatic logic isMulOp(input logic [AluOpBus-1:0]  aluOp,
                                     input logic [OpCodeBus-1:0] opcode);
        return (aluOp == AluOpDecode) && ((opcode == OpMul) || (opcode == OpUmulh));
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative 64x64 unsigned shift-add multiplier: one partial product per cycle, 64 steps.
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic [RegBus-1:0]     opA_i,
    input  logic [RegBus-1:0]     opB_i,
    output logic [2*RegBus-1:0]   product_o,
    output logic                  done_o,
    output logic                  stallreq_o
);

    mul_state_e               state_q, state_d;
    logic [MulCntW-1:0]       count_q, count_d;
    logic [2*RegBus-1:0]      acc_q, acc_d;
    logic [RegBus-1:0]        opA_q, opA_d;
    logic [RegBus-1:0]        opB_q, opB_d;
    logic [2*RegBus-1:0]      partial;

    assign partial   = opB_q[count_q[5:0]] ? ({{RegBus{1'b0}}, opA_q} << count_q[5:0]) : '0;
    assign product_o = acc_q;
    assign done_o    = (state_q == MulDone);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MulIdle;
            count_q <= '0;
            acc_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
        end
    end

    // A flush squashes the instruction in any state, so it overrides everything below.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        stallreq_o = 1'b0;
        if (flush_i) begin
            state_d = MulIdle;
        end else begin
            case (state_q)
                MulIdle: begin
                    if (start_i) begin
                        stallreq_o = 1'b1;
                        opA_d      = opA_i;
                        opB_d      = opB_i;
                        acc_d      = '0;
                        count_d    = '0;
                        state_d    = MulBusy;
                    end
                end
                MulBusy: begin
                    stallreq_o = 1'b1;
                    acc_d      = acc_q + partial;
                    count_d    = count_q + 7'd1;
                    if (count_q == 7'd63) begin
                        state_d = MulDone;
                    end
                end
                MulDone: begin
                    if (!stall_i) begin
                        state_d = MulIdle;
                    end
                end
                default: state_d = MulIdle;
            endcase
        end
        if (!rst) begin
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and the stall interface to the iterative multiplier.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OpCodeBus-1:0]  ex_opcode,
    input  logic [RegBus-1:0]     ex_reg1,
    input  logic [RegBus-1:0]     ex_reg2,
    input  logic [ShamtBus-1:0]   ex_shamt,
    input  logic [RegBus-1:0]     ex_imm,
    input  logic [RegBus-1:0]     ex_pc,
    input  logic                  ex_ALUSrc,
    input  logic [AluOpBus-1:0]   ex_ALUOp,
    input  logic                  ex_isZeroBranch,
    input  logic                  ex_isNZBranch,
    input  logic                  ex_isUnconBranch,
    input  logic                  ex_stall,
    input  logic                  ex_flush,
    output logic [RegBus-1:0]     alu_result,
    output logic                  alu_zero,
    output logic                  branch_taken,
    output logic [RegBus-1:0]     branch_target,
    output logic                  stallreq
);

    logic [RegBus-1:0]    opB;
    logic [RegBus-1:0]    decodeResult;
    logic [2*RegBus-1:0]  product;
    logic                 mulStart;
    logic                 mulDone;

    assign opB      = ex_ALUSrc ? ex_imm : ex_reg2;
    assign mulStart = isMulOp(ex_ALUOp, ex_opcode);

    mul_iter u_mul_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mulStart),
        .flush_i    (ex_flush),
        .stall_i    (ex_stall),
        .opA_i      (ex_reg1),
        .opB_i      (ex_reg2),
        .product_o  (product),
        .done_o     (mulDone),
        .stallreq_o (stallreq)
    );

    // Multiply results only appear once the iterative unit reaches DONE; zero until then.
    always_comb begin
        decodeResult = '0;
        case (ex_opcode)
            OpAdd:   decodeResult = ex_reg1 + opB;
            OpSub:   decodeResult = ex_reg1 - opB;
            OpAnd:   decodeResult = ex_reg1 & opB;
            OpOrr:   decodeResult = ex_reg1 | opB;
            OpLsl:   decodeResult = ex_reg1 << ex_shamt;
            OpLsr:   decodeResult = ex_reg1 >> ex_shamt;
            OpMul:   decodeResult = mulDone ? product[RegBus-1:0] : '0;
            OpUmulh: decodeResult = mulDone ? product[2*RegBus-1:RegBus] : '0;
            default: begin
                case (ex_opcode[OpCodeBus-1:1])
                    OpAddi:  decodeResult = ex_reg1 + opB;
                    OpSubi:  decodeResult = ex_reg1 - opB;
                    OpAndi:  decodeResult = ex_reg1 & opB;
                    OpOrri:  decodeResult = ex_reg1 | opB;
                    default: decodeResult = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (ex_ALUOp)
            AluOpAdd:    alu_result = ex_reg1 + opB;
            AluOpPass:   alu_result = ex_reg2;
            AluOpDecode: alu_result = decodeResult;
            default:     alu_result = '0;
        endcase
    end

    assign alu_zero      = (alu_result == '0);
    assign branch_target = ex_pc + (ex_imm << 2);
    assign branch_taken  = !ex_flush &&
                           (ex_isUnconBranch ||
                            (ex_isZeroBranch && (ex_reg2 == '0)) ||
                            (ex_isNZBranch && (ex_reg2 != '0)));

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: cycle model of ALU, branch and multiplier stall behaviour.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ex_opcode;
    logic [63:0] ex_reg1, ex_reg2, ex_imm, ex_pc;
    logic [5:0]  ex_shamt;
    logic        ex_ALUSrc;
    logic [1:0]  ex_ALUOp;
    logic        ex_isZeroBranch, ex_isNZBranch, ex_isUnconBranch;
    logic        ex_stall, ex_flush;
    logic [63:0] alu_result, branch_target;
    logic        alu_zero, branch_taken, stallreq;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [10:0] opAdd   = 11'b10001011000;
    localparam logic [10:0] opSub   = 11'b11001011000;
    localparam logic [10:0] opAnd   = 11'b10001010000;
    localparam logic [10:0] opOrr   = 11'b10101010000;
    localparam logic [10:0] opLsl   = 11'b11010011011;
    localparam logic [10:0] opLsr   = 11'b11010011010;
    localparam logic [10:0] opMul   = 11'b10011011000;
    localparam logic [10:0] opUmulh = 11'b10011011110;
    localparam logic [9:0]  opAddi  = 10'b1001000100;
    localparam logic [9:0]  opSubi  = 10'b1101000100;
    localparam logic [9:0]  opAndi  = 10'b1001001000;
    localparam logic [9:0]  opOrri  = 10'b1011001000;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_opcode        (ex_opcode),
        .ex_reg1          (ex_reg1),
        .ex_reg2          (ex_reg2),
        .ex_shamt         (ex_shamt),
        .ex_imm           (ex_imm),
        .ex_pc            (ex_pc),
        .ex_ALUSrc        (ex_ALUSrc),
        .ex_ALUOp         (ex_ALUOp),
        .ex_isZeroBranch  (ex_isZeroBranch),
        .ex_isNZBranch    (ex_isNZBranch),
        .ex_isUnconBranch (ex_isUnconBranch),
        .ex_stall         (ex_stall),
        .ex_flush         (ex_flush),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .stallreq         (stallreq)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference ALU: a multiply yields its result only once the model says the product is ready.
    function automatic logic [63:0] refAlu(input logic [1:0] aluOp, input logic [10:0] opc,
                                           input logic [63:0] r1, input logic [63:0] r2,
                                           input logic [63:0] imm, input logic [5:0] sh,
                                           input logic src, input logic ready,
                                           input logic [127:0] prod);
        logic [63:0] b;
        b = src ? imm : r2;
        if (aluOp == 2'b00) return r1 + b;
        if (aluOp == 2'b01) return r2;
        if (aluOp == 2'b11) return 64'd0;
        if (opc == opAdd)   return r1 + b;
        if (opc == opSub)   return r1 - b;
        if (opc == opAnd)   return r1 & b;
        if (opc == opOrr)   return r1 | b;
        if (opc == opLsl)   return r1 << sh;
        if (opc == opLsr)   return r1 >> sh;
        if (opc == opMul)   return ready ? prod[63:0] : 64'd0;
        if (opc == opUmulh) return ready ? prod[127:64] : 64'd0;
        if (opc[10:1] == opAddi) return r1 + b;
        if (opc[10:1] == opSubi) return r1 - b;
        if (opc[10:1] == opAndi) return r1 & b;
        if (opc[10:1] == opOrri) return r1 | b;
        return 64'd0;
    endfunction

    // Model: 0 = free, 1 = computing (cyclesLeft until product ready), 2 = product ready.
    int           mPhase = 0;
    int           mLeft  = 0;
    logic [127:0] mProd;
    logic         isMulIn;

    assign isMulIn = (ex_ALUOp == 2'b10) && ((ex_opcode == opMul) || (ex_opcode == opUmulh));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase <= 0;
            mLeft  <= 0;
        end else if (ex_flush) begin
            mPhase <= 0;
        end else if (mPhase == 0) begin
            if (isMulIn) begin
                mProd  <= {64'd0, ex_reg1} * {64'd0, ex_reg2};
                mLeft  <= 64;
                mPhase <= 1;
            end
        end else if (mPhase == 1) begin
            mLeft <= mLeft - 1;
            if (mLeft == 1) mPhase <= 2;
        end else if (!ex_stall) begin
            mPhase <= 0;
        end
    end

    always @(negedge clk) begin : compareProc
        logic [63:0] expAlu;
        logic        expTaken, expStall;
        expAlu   = refAlu(ex_ALUOp, ex_opcode, ex_reg1, ex_reg2, ex_imm, ex_shamt, ex_ALUSrc,
                          mPhase == 2, mProd);
        expStall = rst && !ex_flush && ((mPhase == 1) || ((mPhase == 0) && isMulIn));
        expTaken = !ex_flush && (ex_isUnconBranch || (ex_isZeroBranch && ex_reg2 == 64'd0) ||
                                 (ex_isNZBranch && ex_reg2 != 64'd0));
        checkOutput("model alu_result", alu_result, expAlu);
        checkOutput("model alu_zero", {63'd0, alu_zero}, {63'd0, expAlu == 64'd0});
        checkOutput("model branch_taken", {63'd0, branch_taken}, {63'd0, expTaken});
        checkOutput("model branch_target", branch_target, ex_pc + (ex_imm << 2));
        checkOutput("model stallreq", {63'd0, stallreq}, {63'd0, expStall});
    end

    task automatic applyStimulus(input logic [1:0] aluOp, input logic [10:0] opc,
                                 input logic [63:0] r1, input logic [63:0] r2,
                                 input logic src, input logic [63:0] imm, input logic [5:0] sh);
        ex_ALUOp  = aluOp;
        ex_opcode = opc;
        ex_reg1   = r1;
        ex_reg2   = r2;
        ex_ALUSrc = src;
        ex_imm    = imm;
        ex_shamt  = sh;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic runVector(input string name, input logic [1:0] aluOp, input logic [10:0] opc,
                             input logic [63:0] r1, input logic [63:0] r2, input logic src,
                             input logic [63:0] imm, input logic [5:0] sh, input logic [63:0] expected);
        applyStimulus(aluOp, opc, r1, r2, src, imm, sh);
        #1;
        checkOutput(name, alu_result, expected);
        checkOutput({name, " zero"}, {63'd0, alu_zero}, {63'd0, expected == 64'd0});
        nextCycle();
    endtask

    // Starts a multiply and counts stall cycles until DONE; leaves the bench in the DONE cycle.
    task automatic runMul(input string name, input logic [10:0] opc, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] expResult);
        int stallCycles;
        stallCycles = 0;
        applyStimulus(2'b10, opc, a, b, 1'b0, 64'd0, 6'd0);
        #1;
        while (stallreq === 1'b1 && stallCycles < 200) begin
            stallCycles++;
            @(posedge clk);
            #3;
        end
        checkOutput({name, " stall cycles"}, 64'(stallCycles), 64'd65);
        checkOutput({name, " result"}, alu_result, expResult);
    endtask

    initial begin
        rst              = 1'b0;
        ex_stall         = 1'b0;
        ex_flush         = 1'b0;
        ex_pc            = 64'd0;
        ex_isZeroBranch  = 1'b0;
        ex_isNZBranch    = 1'b0;
        ex_isUnconBranch = 1'b0;
        applyStimulus(2'b10, opMul, 64'd3, 64'd4, 1'b0, 64'd0, 6'd0);
        #1;
        checkOutput("reset stallreq", {63'd0, stallreq}, 64'd0);
        checkOutput("reset mul alu_result", alu_result, 64'd0);

        repeat (2) @(posedge clk);
        #2;
        applyStimulus(2'b10, opAdd, 64'd5, 64'd7, 1'b0, 64'd0, 6'd0);
        rst = 1'b1;
        #1;
        checkOutput("add 5+7", alu_result, 64'd12);
        checkOutput("add zero", {63'd0, alu_zero}, 64'd0);
        nextCycle();
        runVector("sub 7-7", 2'b10, opSub, 64'd7, 64'd7, 1'b0, 64'd0, 6'd0, 64'd0);
        runVector("and", 2'b10, opAnd, 64'hF0F0, 64'hFF00, 1'b0, 64'd0, 6'd0, 64'hF000);
        runVector("orr", 2'b10, opOrr, 64'hF0F0, 64'h0F0F, 1'b0, 64'd0, 6'd0, 64'hFFFF);
        runVector("lsl 63", 2'b10, opLsl, 64'd1, 64'd9, 1'b0, 64'd0, 6'd63, 64'h8000_0000_0000_0000);
        runVector("lsr 4", 2'b10, opLsr, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 64'd0, 6'd4,
                  64'h0800_0000_0000_0000);
        runVector("addi", 2'b10, 11'b10010001001, 64'd10, 64'd99, 1'b1, 64'd5, 6'd0, 64'd15);
        runVector("subi wrap", 2'b10, 11'b11010001000, 64'd3, 64'd0, 1'b1, 64'd5, 6'd0,
                  64'hFFFF_FFFF_FFFF_FFFE);
        runVector("andi", 2'b10, 11'b10010010001, 64'hFF, 64'd0, 1'b1, 64'h3C, 6'd0, 64'h3C);
        runVector("orri", 2'b10, 11'b10110010000, 64'h100, 64'd0, 1'b1, 64'd1, 6'd0, 64'h101);
        runVector("add imm src", 2'b10, opAdd, 64'd100, 64'd999, 1'b1, 64'd23, 6'd0, 64'd123);
        runVector("aluop00 wrap", 2'b00, opSub, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 6'd0, 64'd0);
        runVector("aluop01 pass", 2'b01, opAdd, 64'd5, 64'h1234, 1'b0, 64'd0, 6'd0, 64'h1234);
        runVector("aluop11", 2'b11, opAdd, 64'd5, 64'd6, 1'b0, 64'd0, 6'd0, 64'd0);
        runVector("unmatched op", 2'b10, 11'b11111111111, 64'd5, 64'd6, 1'b0, 64'd0, 6'd0, 64'd0);

        applyStimulus(2'b01, opAdd, 64'd0, 64'd0, 1'b0, 64'd3, 6'd0);
        ex_pc           = 64'h100;
        ex_isZeroBranch = 1'b1;
        #1;
        checkOutput("cbz taken", {63'd0, branch_taken}, 64'd1);
        checkOutput("cbz target", branch_target, 64'h10C);
        ex_flush = 1'b1;
        #1;
        checkOutput("cbz flushed", {63'd0, branch_taken}, 64'd0);
        nextCycle();
        ex_flush        = 1'b0;
        ex_isZeroBranch = 1'b0;
        ex_isNZBranch   = 1'b1;
        ex_reg2         = 64'd5;
        #1;
        checkOutput("cbnz taken", {63'd0, branch_taken}, 64'd1);
        nextCycle();
        ex_reg2 = 64'd0;
        #1;
        checkOutput("cbnz not taken", {63'd0, branch_taken}, 64'd0);
        nextCycle();
        ex_isNZBranch    = 1'b0;
        ex_isUnconBranch = 1'b1;
        ex_imm           = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkOutput("b taken", {63'd0, branch_taken}, 64'd1);
        checkOutput("b backward target", branch_target, 64'hFC);
        nextCycle();
        ex_isUnconBranch = 1'b0;

        runMul("mul", opMul, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);
        applyStimulus(2'b01, opAdd, 64'd0, 64'd9, 1'b0, 64'd0, 6'd0);
        @(posedge clk);
        #3;
        checkOutput("idle after mul", {63'd0, stallreq}, 64'd0);
        @(posedge clk);
        #2;

        runMul("umulh", opUmulh, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #3;
            checkOutput("umulh held stallreq", {63'd0, stallreq}, 64'd0);
            checkOutput("umulh held result", alu_result, 64'd1);
        end
        ex_stall = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("back-to-back start", {63'd0, stallreq}, 64'd1);
        checkOutput("back-to-back pending alu", alu_result, 64'd0);
        repeat (11) @(posedge clk);
        #3;
        checkOutput("busy step 10 stallreq", {63'd0, stallreq}, 64'd1);
        ex_flush = 1'b1;
        #1;
        checkOutput("flush drops stallreq", {63'd0, stallreq}, 64'd0);
        nextCycle();
        ex_flush = 1'b0;
        applyStimulus(2'b01, opAdd, 64'd0, 64'h55, 1'b0, 64'd0, 6'd0);
        #1;
        checkOutput("idle after flush", {63'd0, stallreq}, 64'd0);
        checkOutput("alu after flush", alu_result, 64'h55);
        nextCycle();

        applyStimulus(2'b10, opMul, 64'd6, 64'd7, 1'b0, 64'd0, 6'd0);
        #1;
        checkOutput("mul2 start", {63'd0, stallreq}, 64'd1);
        repeat (31) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async reset stallreq", {63'd0, stallreq}, 64'd0);
        checkOutput("async reset alu", alu_result, 64'd0);
        nextCycle();
        rst = 1'b1;
        runMul("mul after reset", opMul, 64'd6, 64'd7, 64'd42);
        applyStimulus(2'b01, opAdd, 64'd0, 64'd1, 1'b0, 64'd0, 6'd0);
        repeat (3) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
